// File: rtl/rca_pipe_p.sv
// rca_pipe_p: segmented, pipelined ripple-carry adder with valid/ready
// handshake at both ends. One SEG-bit ripple segment is added per stage,
// giving NSEG = SIZE/SEG stages and a capacity of NSEG transactions.
// APPROX=1 replaces the carry into segments 1..APX_SEGS with the generate
// of the previous segment's MSB.
// Optional: define RCA_PIPE_ERR_FLAG_EN to add the ERR output, driven by a
// shadow exact carry chain carried alongside each stage.

module rca_pipe_p #(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned SEG      = 4,
  parameter int unsigned APX_SEGS = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [SIZE:1] A,
  input  logic [SIZE:1] B,
  input  logic          CIN,
  input  logic          APPROX,
  input  logic          IN_VALID,
  output logic          IN_READY,
  output logic [SIZE:1] SUM,
  output logic          COUT,
  output logic          OUT_VALID,
  input  logic          OUT_READY
`ifdef RCA_PIPE_ERR_FLAG_EN
  ,
  output logic          ERR
`endif
);

  localparam int unsigned NSEG = SIZE / SEG;

  // Stage registers: entry k holds the result after segment k is added.
  logic [NSEG-1:0] valid_q;
  logic [NSEG-1:0] carry_q;
  logic            mode_q  [NSEG];
  logic [SIZE-1:0] sum_q   [NSEG];
  logic [SIZE-1:0] a_q     [NSEG];
  logic [SIZE-1:0] b_q     [NSEG];

  // Values presented to each stage register (inputs of stage k).
  logic [NSEG-1:0] valid_d;
  logic [NSEG-1:0] carry_d;
  logic [NSEG-1:0] ready;
  logic            mode_d  [NSEG];
  logic [SIZE-1:0] sum_d   [NSEG];
  logic [SIZE-1:0] a_d     [NSEG];
  logic [SIZE-1:0] b_d     [NSEG];

`ifdef RCA_PIPE_ERR_FLAG_EN
  logic [NSEG-1:0] err_q;
  logic [NSEG-1:0] err_d;
  logic            tcarry_q [NSEG];
  logic            tcarry_d [NSEG];
`endif

  // Backward ready chain: a stage can load when it is empty or its
  // successor is loading; the last stage drains into OUT_READY.
  always_comb begin
    logic rdy;
    rdy   = OUT_READY;
    ready = '0;
    for (int unsigned i = 0; i < NSEG; i++) begin
      rdy                 = !valid_q[NSEG-1-i] || rdy;
      ready[NSEG-1-i]     = rdy;
    end
  end

  // Per-stage segment addition, sourced from the ports for stage 0 and
  // from the previous stage register otherwise.
  always_comb begin
    logic [SIZE-1:0] src_sum;
    logic            src_c;
    logic            cin;
    logic [SEG:0]    seg;
`ifdef RCA_PIPE_ERR_FLAG_EN
    logic            tc_in;
    logic            err_in;
    logic [SEG:0]    tseg;
`endif
    for (int unsigned k = 0; k < NSEG; k++) begin
      if (k == 0) begin
        a_d[k]     = A;
        b_d[k]     = B;
        mode_d[k]  = APPROX;
        valid_d[k] = IN_VALID;
        src_sum    = '0;
        src_c      = CIN;
      end else begin
        a_d[k]     = a_q[k-1];
        b_d[k]     = b_q[k-1];
        mode_d[k]  = mode_q[k-1];
        valid_d[k] = valid_q[k-1];
        src_sum    = sum_q[k-1];
        src_c      = carry_q[k-1];
      end
      cin = src_c;
      if (mode_d[k] && (k >= 1) && (k <= APX_SEGS))
        cin = a_d[k][SEG*k-1] & b_d[k][SEG*k-1];
      seg = {1'b0, a_d[k][SEG*k +: SEG]} + {1'b0, b_d[k][SEG*k +: SEG]}
          + {{SEG{1'b0}}, cin};
      sum_d[k]               = src_sum;
      sum_d[k][SEG*k +: SEG] = seg[SEG-1:0];
      carry_d[k]             = seg[SEG];
`ifdef RCA_PIPE_ERR_FLAG_EN
      // Exact carry runs beside the delivered one; any segment or final
      // carry disagreement marks the transaction as inexact.
      tc_in  = (k == 0) ? CIN  : tcarry_q[k-1];
      err_in = (k == 0) ? 1'b0 : err_q[k-1];
      tseg   = {1'b0, a_d[k][SEG*k +: SEG]} + {1'b0, b_d[k][SEG*k +: SEG]}
             + {{SEG{1'b0}}, tc_in};
      tcarry_d[k] = tseg[SEG];
      err_d[k]    = err_in || (tseg[SEG-1:0] != seg[SEG-1:0])
                  || ((k == NSEG-1) && (tseg[SEG] != seg[SEG]));
`endif
    end
  end

  // Stage registers advance independently whenever their ready is high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= '0;
      carry_q <= '0;
`ifdef RCA_PIPE_ERR_FLAG_EN
      err_q   <= '0;
`endif
      for (int unsigned k = 0; k < NSEG; k++) begin
        mode_q[k] <= 1'b0;
        sum_q[k]  <= '0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
`ifdef RCA_PIPE_ERR_FLAG_EN
        tcarry_q[k] <= 1'b0;
`endif
      end
    end else begin
      for (int unsigned k = 0; k < NSEG; k++) begin
        if (ready[k]) begin
          valid_q[k] <= valid_d[k];
          if (valid_d[k]) begin
            mode_q[k]  <= mode_d[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
`ifdef RCA_PIPE_ERR_FLAG_EN
            tcarry_q[k] <= tcarry_d[k];
            err_q[k]    <= err_d[k];
`endif
          end
        end
      end
    end
  end

  assign IN_READY  = ready[0];
  assign OUT_VALID = valid_q[NSEG-1];
  assign SUM       = sum_q[NSEG-1];
  assign COUT      = carry_q[NSEG-1];
`ifdef RCA_PIPE_ERR_FLAG_EN
  assign ERR       = err_q[NSEG-1];
`endif

endmodule

// File: tb/tb_rca_pipe_p.sv
// Directed bench for rca_pipe_p: vector table of single transactions plus
// hand-written backpressure and mid-flight reset sequences.

module tb_rca_pipe_p;

  localparam int unsigned SIZE     = 16;
  localparam int unsigned SEG      = 4;
  localparam int unsigned APX_SEGS = 2;
  localparam int unsigned NSEG     = SIZE / SEG;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [SIZE:1]   A = '0;
  logic [SIZE:1]   B = '0;
  logic            CIN = 1'b0;
  logic            APPROX = 1'b0;
  logic            IN_VALID = 1'b0;
  logic            IN_READY;
  logic [SIZE:1]   SUM;
  logic            COUT;
  logic            OUT_VALID;
  logic            OUT_READY = 1'b1;
`ifdef RCA_PIPE_ERR_FLAG_EN
  logic            ERR;
`endif

  rca_pipe_p #(
    .SIZE    (SIZE),
    .SEG     (SEG),
    .APX_SEGS(APX_SEGS)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .A        (A),
    .B        (B),
    .CIN      (CIN),
    .APPROX   (APPROX),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .SUM      (SUM),
    .COUT     (COUT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY)
`ifdef RCA_PIPE_ERR_FLAG_EN
    ,
    .ERR      (ERR)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        apx;
    logic [15:0] sum;
    logic        cout;
    logic        err;
    string       name;
  } vec_t;

  vec_t vecs [11];

  task automatic send_one(input vec_t v);
    int cyc;
    @(negedge CLK);
    A = v.a; B = v.b; CIN = v.cin; APPROX = v.apx;
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    #1 check({v.name, "_in_ready"}, IN_READY, 1);
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!OUT_VALID && cyc < 16);
    // Output is taken at accept edge + cyc.
    check({v.name, "_latency"}, cyc, NSEG);
    check({v.name, "_sum"}, SUM, v.sum);
    check({v.name, "_cout"}, COUT, v.cout);
`ifdef RCA_PIPE_ERR_FLAG_EN
    check({v.name, "_err"}, ERR, v.err);
`endif
    @(negedge CLK);
    check({v.name, "_drained"}, OUT_VALID, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int occ, sent, got, acc, del;
    logic saw_block;

    vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "exact_ff_1"};
    vecs[1]  = '{16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h00F0, 1'b0, 1'b1, "apx_ff_1"};
    vecs[2]  = '{16'h0088, 16'h0088, 1'b0, 1'b1, 16'h0110, 1'b0, 1'b0, "apx_88_88"};
    vecs[3]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap_ffff_1"};
    vecs[4]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "wrap_ffff_ffff_c"};
    vecs[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "exact_mixed"};
    vecs[6]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'hFFF0, 1'b0, 1'b1, "apx_ffff_1"};
    vecs[7]  = '{16'h8888, 16'h8888, 1'b0, 1'b1, 16'h1110, 1'b1, 1'b0, "apx_8888"};
    vecs[8]  = '{16'h000F, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, "apx_cin_lost"};
    vecs[9]  = '{16'h0F00, 16'h0100, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, "apx_top_true"};
    vecs[10] = '{16'h0088, 16'h0078, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "exact_ripple"};

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_sum", SUM, 0);
    check("rst_cout", COUT, 0);
    check("rst_in_ready", IN_READY, 1);
`ifdef RCA_PIPE_ERR_FLAG_EN
    check("rst_err", ERR, 0);
`endif

    for (int i = 0; i < 11; i++) send_one(vecs[i]);

    // Backpressure: i + 2i for i = 1..6, OUT_READY low on cycles 4..6.
    occ = 0; sent = 0; got = 0; saw_block = 1'b0;
    for (int c = 1; c <= 40 && got < 6; c++) begin
      @(negedge CLK);
      OUT_READY = !(c >= 4 && c <= 6);
      if (sent < 6) begin
        IN_VALID = 1'b1; A = 16'(sent + 1); B = 16'(2 * (sent + 1));
        CIN = 1'b0; APPROX = 1'b0;
      end else begin
        IN_VALID = 1'b0;
      end
      #1;
      check("bp_in_ready", IN_READY, (occ < int'(NSEG)) || OUT_READY);
      if (!IN_READY) saw_block = 1'b1;
      acc = int'(IN_VALID && IN_READY);
      del = int'(OUT_VALID && OUT_READY);
      if (OUT_VALID) begin
        check("bp_sum", SUM, 32'(3 * (got + 1)));
        check("bp_cout", COUT, 0);
      end
      got  = got + del;
      sent = sent + acc;
      occ  = occ + acc - del;
    end
    check("bp_delivered", got, 6);
    check("bp_blocked_seen", saw_block, 1);
    @(negedge CLK);
    check("bp_no_extra", OUT_VALID, 0);

    // Mid-flight reset with three transactions in the pipe.
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b1; A = 16'(16'h1111 * (i + 1)); B = 16'h0101;
      CIN = 1'b0; APPROX = 1'b0;
      #1 check("mr_in_ready", IN_READY, 1);
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    @(negedge CLK);
    #1;
    check("mr_pre_valid", OUT_VALID, 1);
    check("mr_pre_sum", SUM, 32'h1212);
    RST_N = 1'b0;
    #1;
    check("mr_valid", OUT_VALID, 0);
    check("mr_sum", SUM, 0);
    check("mr_cout", COUT, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("mr_no_stale", OUT_VALID, 0);
    end
    send_one(vecs[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
